// File: rtl/tetris_pkg.sv
// Shared game-flow types and constants: state codes, default keycodes, state width.
package tetris_pkg;

    localparam int GS_W = 3;

    localparam logic [15:0] KEY_ENTER = 16'h0028;
    localparam logic [15:0] KEY_P     = 16'h0013;

    typedef enum logic [GS_W-1:0] {
        GS_IDLE      = 3'd1,
        GS_COUNTDOWN = 3'd2,
        GS_PLAY      = 3'd3,
        GS_PAUSE     = 3'd4,
        GS_OVER      = 3'd5
    } game_state_t;

endpackage

// File: rtl/game_flow_fsm_key_edge.sv
// Single-key press detector: one-cycle pulse when keycode first matches MATCH.
module key_edge #(
    parameter int               KEY_W = 16,
    parameter logic [KEY_W-1:0] MATCH = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [KEY_W-1:0] keycode,
    output logic             press
);

    logic [KEY_W-1:0] prev_key;

    // prev_key clears on reset so a key held through reset still fires once.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prev_key <= '0;
        end else begin
            prev_key <= keycode;
        end
    end

    assign press = (keycode == MATCH) && (prev_key != MATCH);

endmodule

// File: rtl/game_flow_fsm.sv
// Game flow controller: IDLE/COUNTDOWN/PLAY/PAUSE/OVER sequencing with registered outputs.
// Optional pause support is enabled by defining GAME_FLOW_PAUSE_EN.
module game_flow_fsm
    import tetris_pkg::*;
#(
    parameter int               KEY_W     = 16,
    parameter logic [KEY_W-1:0] KEY_START = KEY_W'(KEY_ENTER),
    parameter logic [KEY_W-1:0] KEY_PAUSE = KEY_W'(KEY_P),
    parameter int               CD_TICKS  = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_tick,
    input  logic             endgame,
    input  logic [KEY_W-1:0] keycode,
    output logic             reset_game,
    output logic [GS_W-1:0]  gamestate,
    output logic [7:0]       cd_value,
    output logic             run_en
);

    localparam logic [7:0] CD_LOAD = 8'(CD_TICKS);

    game_state_t state_q, state_n;
    logic [7:0]  cd_q, cd_n;
    logic        reset_game_n;
    logic        run_en_n;
    logic        start_ev;
    logic        pause_ev;

    key_edge #(
        .KEY_W (KEY_W),
        .MATCH (KEY_START)
    ) u_start_edge (
        .Clk     (Clk),
        .Reset   (Reset),
        .keycode (keycode),
        .press   (start_ev)
    );

`ifdef GAME_FLOW_PAUSE_EN
    key_edge #(
        .KEY_W (KEY_W),
        .MATCH (KEY_PAUSE)
    ) u_pause_edge (
        .Clk     (Clk),
        .Reset   (Reset),
        .keycode (keycode),
        .press   (pause_ev)
    );
`else
    localparam logic [KEY_W-1:0] UNUSED_KEY_PAUSE = KEY_PAUSE;
    assign pause_ev = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= GS_IDLE;
            cd_q       <= '0;
            reset_game <= 1'b0;
            run_en     <= 1'b0;
        end else begin
            state_q    <= state_n;
            cd_q       <= cd_n;
            reset_game <= reset_game_n;
            run_en     <= run_en_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        cd_n         = '0;
        reset_game_n = 1'b0;

        case (state_q)
            GS_IDLE: begin
                if (start_ev) begin
                    state_n      = GS_COUNTDOWN;
                    cd_n         = CD_LOAD;
                    reset_game_n = 1'b1;
                end
            end

            GS_COUNTDOWN: begin
                cd_n = cd_q;
                if (frame_tick) begin
                    if (cd_q <= 8'd1) begin
                        state_n = GS_PLAY;
                        cd_n    = '0;
                    end else begin
                        cd_n = cd_q - 8'd1;
                    end
                end
            end

            GS_PLAY: begin
                if (endgame) begin
                    state_n = GS_OVER;
                end else if (pause_ev) begin
`ifdef GAME_FLOW_PAUSE_EN
                    state_n = GS_PAUSE;
`endif
                end
            end

`ifdef GAME_FLOW_PAUSE_EN
            GS_PAUSE: begin
                // Restart takes priority over resume.
                if (start_ev) begin
                    state_n      = GS_COUNTDOWN;
                    cd_n         = CD_LOAD;
                    reset_game_n = 1'b1;
                end else if (pause_ev) begin
                    state_n = GS_PLAY;
                end
            end
`endif

            GS_OVER: begin
                if (start_ev) begin
                    state_n      = GS_COUNTDOWN;
                    cd_n         = CD_LOAD;
                    reset_game_n = 1'b1;
                end
            end

            default: begin
                state_n = GS_IDLE;
            end
        endcase

        run_en_n = (state_n == GS_PLAY);
    end

    assign gamestate = state_q;
    assign cd_value  = cd_q;

endmodule
